imm_ext_stage: RTL and testbench

- Registered, parametrised immediate-extension stage for the pipelined MIPS datapath, sitting between decode and execute.
- Takes the instruction immediate and shamt fields plus an extension opcode, and produces a DATA_W-bit operand.
- Uses a 2-entry valid/ready skid buffer, so the stage absorbs one cycle of downstream stall without dropping data.
- Supports flush, and flags illegal extension opcodes.

---
 rtl/imm_ext_stage_if.sv | 26 ++
 rtl/imm_ext_stage.sv | 147 ++++++++++++++
 tb/tb_imm_ext_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_stage_if.sv
// Handshake/bus bundle for imm_ext_stage: request side (decode) and result side (execute).
interface imm_ext_stage_if #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [IMM_W-1:0]   imm;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]         extop;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  ext_out;
  logic               illegal;

  modport master (
    output in_valid, imm, shamt, extop, out_ready,
    input  in_ready, out_valid, ext_out, illegal
  );

  modport slave (
    input  in_valid, imm, shamt, extop, out_ready,
    output in_ready, out_valid, ext_out, illegal
  );
endinterface

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer between decode and execute.
// Optional macro EXT_ILLEGAL_CNT_EN adds a saturating 16-bit count of accepted illegal extops.
module imm_ext_stage #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  imm_ext_stage_if.slave      bus
`ifdef EXT_ILLEGAL_CNT_EN
  ,
  output logic [15:0]         illegal_cnt
`endif
);

  typedef enum logic [2:0] {
    EXT_SIGN   = 3'b000,
    EXT_ZERO   = 3'b001,
    EXT_SHAMT  = 3'b010,
    EXT_UPPER  = 3'b011,
    EXT_BRANCH = 3'b100
  } ext_mode_e;

  // Occupancy: main register drives the outputs, skid only holds data when main is stalled.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_FULL
  } occ_e;

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_ill_q, main_ill_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_ill_q, skid_ill_d;

  ext_mode_e         ext_mode;
  logic [DATA_W-1:0] sext_imm;
  logic [DATA_W-1:0] ext_data;
  logic              ext_ill;
  logic              in_ready_c;
  logic              accept;
  logic              drain;

  assign ext_mode = ext_mode_e'(bus.extop);

  always_comb begin
    sext_imm = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    ext_data = '0;
    ext_ill  = 1'b0;
    case (ext_mode)
      EXT_SIGN:   ext_data = sext_imm;
      EXT_ZERO:   ext_data = {{(DATA_W-IMM_W){1'b0}}, bus.imm};
      EXT_SHAMT:  ext_data = {{(DATA_W-SHAMT_W){1'b0}}, bus.shamt};
      EXT_UPPER:  ext_data = {bus.imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_BRANCH: ext_data = sext_imm << 2;
      default:    ext_ill  = 1'b1;
    endcase
  end

  // in_ready depends only on registered state and rst, never on out_ready.
  assign in_ready_c = (state_q != ST_FULL) && !rst;
  assign accept     = bus.in_valid && in_ready_c;
  assign drain      = (state_q != ST_EMPTY) && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ill_d  = main_ill_q;
    skid_data_d = skid_data_q;
    skid_ill_d  = skid_ill_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_MAIN;
            main_data_d = ext_data;
            main_ill_d  = ext_ill;
          end
        end
        ST_MAIN: begin
          if (accept && drain) begin
            main_data_d = ext_data;
            main_ill_d  = ext_ill;
          end else if (accept) begin
            state_d     = ST_FULL;
            skid_data_d = ext_data;
            skid_ill_d  = ext_ill;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d     = ST_MAIN;
            main_data_d = skid_data_q;
            main_ill_d  = skid_ill_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ill_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ill_q  <= main_ill_d;
      skid_data_q <= skid_data_d;
      skid_ill_q  <= skid_ill_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.ext_out   = main_data_q;
  assign bus.illegal   = main_ill_q;

`ifdef EXT_ILLEGAL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counted at accept time, so a later flush does not undo it.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && ext_ill && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: queue-based reference model plus literal expectations.
module tb_imm_ext_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush;
`ifdef EXT_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  always #5 clk = ~clk;

  imm_ext_stage_if #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5)) bus ();

  imm_ext_stage #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef EXT_ILLEGAL_CNT_EN
    ,
    .illegal_cnt (illegal_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic        ill;
  } res_t;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  res_t        mq[$];
  logic [15:0] m_cnt = '0;
  bit          started = 1'b0;

  function automatic res_t ref_ext(logic [15:0] i, logic [4:0] s, logic [2:0] op);
    longint sv;
    res_t   r;
    sv    = longint'($signed(i));
    r.ill = 1'b0;
    case (op)
      3'd0:    r.d = 32'(sv);
      3'd1:    r.d = 32'(i);
      3'd2:    r.d = 32'(s);
      3'd3:    r.d = 32'(longint'(i) * 65536);
      3'd4:    r.d = 32'(sv * 4);
      default: begin r.d = '0; r.ill = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: updated from the inputs present at each rising edge.
  always @(posedge clk) begin
    bit   acc, drn;
    res_t r;
    started = 1'b1;
    acc = bus.in_valid && (mq.size() < 2) && !rst;
    drn = (mq.size() > 0) && bus.out_ready;
    r   = ref_ext(bus.imm, bus.shamt, bus.extop);
    if (rst) begin
      mq.delete();
      m_cnt = '0;
    end else begin
      if (acc && r.ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (flush) mq.delete();
      else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(r);
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("model_out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
      chk("model_in_ready", 64'(bus.in_ready), 64'((mq.size() < 2) && !rst));
      if (mq.size() > 0) begin
        chk("model_ext_out", 64'(bus.ext_out), 64'(mq[0].d));
        chk("model_illegal", 64'(bus.illegal), 64'(mq[0].ill));
      end
`ifdef EXT_ILLEGAL_CNT_EN
      chk("model_illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
`endif
    end
  end

  // All stimulus tasks start and end at posedge+2.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] i, input logic [4:0] s, input logic [2:0] op);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.imm      = i;
    bus.shamt    = s;
    bus.extop    = op;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic expect_out(input string nm, input logic [31:0] d, input logic ill);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk({nm, "_valid"}, 64'(seen), 64'(1));
    chk({nm, "_ext_out"}, 64'(bus.ext_out), 64'(d));
    chk({nm, "_illegal"}, 64'(bus.illegal), 64'(ill));
    step();
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.imm       = '0;
    bus.shamt     = '0;
    bus.extop     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_ext_out", 64'(bus.ext_out), 64'(0));
    chk("rst_illegal", 64'(bus.illegal), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    step();

    // Extension modes
    send(16'h8001, 5'h00, 3'b000); expect_out("sext",   32'hFFFF8001, 1'b0);
    send(16'h8001, 5'h00, 3'b001); expect_out("zext",   32'h00008001, 1'b0);
    send(16'h1234, 5'h00, 3'b011); expect_out("upper",  32'h12340000, 1'b0);
    send(16'hFFFF, 5'h00, 3'b100); expect_out("branch", 32'hFFFFFFFC, 1'b0);
    send(16'h0000, 5'h1F, 3'b010); expect_out("shamt",  32'h0000001F, 1'b0);

    // Stall and skid
    bus.out_ready = 1'b0;
    send(16'd1, 5'd0, 3'b001);
    send(16'd2, 5'd0, 3'b001);
    @(negedge clk);
    chk("stall_hold_ext_out", 64'(bus.ext_out), 64'(1));
    chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain_first", 64'(bus.ext_out), 64'(1));
    step();
    @(negedge clk);
    chk("drain_second", 64'(bus.ext_out), 64'(2));
    chk("drain_in_ready", 64'(bus.in_ready), 64'(1));
    step();
    @(negedge clk);
    chk("drain_empty", 64'(bus.out_valid), 64'(0));
    step();

    // Illegal opcode
`ifdef EXT_ILLEGAL_CNT_EN
    chk("cnt_before", 64'(illegal_cnt), 64'(0));
`endif
    send(16'hABCD, 5'd0, 3'b111);
    expect_out("illegal", 32'h0, 1'b1);
`ifdef EXT_ILLEGAL_CNT_EN
    chk("cnt_after", 64'(illegal_cnt), 64'(1));
`endif

    // Flush with both entries full and a concurrent request
    bus.out_ready = 1'b0;
    send(16'd3, 5'd0, 3'b001);
    send(16'd4, 5'd0, 3'b001);
    flush = 1'b1; bus.in_valid = 1'b1; bus.imm = 16'd5; bus.extop = 3'b001;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
    chk("flush_in_ready", 64'(bus.in_ready), 64'(1));
    step();
    // Flush while main holds one entry and the concurrent request would be accepted
    send(16'd6, 5'd0, 3'b001);
    flush = 1'b1; bus.in_valid = 1'b1; bus.imm = 16'd7;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("flush_no_ghost", 64'(bus.out_valid), 64'(0));
      step();
    end

    // Reset mid-stall
    bus.out_ready = 1'b0;
    send(16'd8, 5'd0, 3'b001);
    send(16'd9, 5'd0, 3'b001);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    @(negedge clk);
    chk("rst2_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst2_ext_out", 64'(bus.ext_out), 64'(0));
    chk("rst2_illegal", 64'(bus.illegal), 64'(0));
    chk("rst2_in_ready", 64'(bus.in_ready), 64'(0));
`ifdef EXT_ILLEGAL_CNT_EN
    chk("rst2_cnt", 64'(illegal_cnt), 64'(0));
`endif
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(16'h7FFF, 5'd0, 3'b000);
    expect_out("post_rst", 32'h00007FFF, 1'b0);

    // Throughput: one accept per cycle, one result per cycle
    for (int unsigned i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.imm      = 16'(10 + i);
      bus.extop    = 3'b001;
      @(negedge clk);
      chk("tp_in_ready", 64'(bus.in_ready), 64'(1));
      if (i > 0) begin
        chk("tp_out_valid", 64'(bus.out_valid), 64'(1));
        chk("tp_ext_out", 64'(bus.ext_out), 64'(10 + i - 1));
      end
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("tp_last", 64'(bus.ext_out), 64'(17));
    step();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
